// File: rtl/des_pkg.sv
// Shared types and constants for the DES datapath.
package des_pkg;

    typedef logic [63:0] des_block_t;
    typedef logic [31:0] des_half_t;

    localparam int unsigned DES_ROUNDS = 16;

endpackage : des_pkg

// File: rtl/des_out_stage_inverse_p.sv
// DES final permutation (inverse initial permutation), purely combinational.
// Bus index 0 carries DES bit 1 on both sides.
module InverseP
    import des_pkg::*;
(
    input  logic [63:0] block_in,
    output logic [63:0] block_out
);

    // Zero-based source index for each output index (DES FP table minus one).
    localparam logic [5:0] FP_SRC [64] = '{
        6'd39, 6'd7, 6'd47, 6'd15, 6'd55, 6'd23, 6'd63, 6'd31,
        6'd38, 6'd6, 6'd46, 6'd14, 6'd54, 6'd22, 6'd62, 6'd30,
        6'd37, 6'd5, 6'd45, 6'd13, 6'd53, 6'd21, 6'd61, 6'd29,
        6'd36, 6'd4, 6'd44, 6'd12, 6'd52, 6'd20, 6'd60, 6'd28,
        6'd35, 6'd3, 6'd43, 6'd11, 6'd51, 6'd19, 6'd59, 6'd27,
        6'd34, 6'd2, 6'd42, 6'd10, 6'd50, 6'd18, 6'd58, 6'd26,
        6'd33, 6'd1, 6'd41, 6'd9,  6'd49, 6'd17, 6'd57, 6'd25,
        6'd32, 6'd0, 6'd40, 6'd8,  6'd48, 6'd16, 6'd56, 6'd24
    };

    des_block_t permuted;

    // Fixed wiring of each output bit to its source bit.
    for (genvar g = 0; g < 64; g++) begin : g_fp
        assign permuted[g] = block_in[FP_SRC[g]];
    end

    assign block_out = permuted;

endmodule : InverseP

// File: rtl/des_out_stage.sv
// DES output stage: R16/L16 swap, final permutation, and a small
// non-stallable-input FIFO with valid/ready output, early almost_full
// warning and sticky drop flag.
module des_out_stage
    import des_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int TAG_W     = 4,
    parameter int AF_MARGIN = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [31:0]              in_l16,
    input  logic [31:0]              in_r16,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     almost_full,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [63:0]              out_data,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 64 + TAG_W;

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] MARGIN_C = CW'(AF_MARGIN);

    des_block_t preout;
    des_block_t out_word;

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_next;
    logic          push;
    logic          pop;
    logic          drop;
    logic          af_next;

    // R16 occupies DES bits 1..32, L16 bits 33..64 (the final swap).
    assign preout = {in_l16, in_r16};

    InverseP u_fp (
        .block_in  (preout),
        .block_out (out_word)
    );

    // Handshake decode and next-state occupancy.
    always_comb begin
        pop        = (count_q != '0) && out_ready;
        push       = in_valid && ((count_q < DEPTH_C) || pop);
        drop       = in_valid && (count_q == DEPTH_C) && !pop;
        count_next = count_q;
        case ({push, pop})
            2'b10:   count_next = count_q + CW'(1);
            2'b01:   count_next = count_q - CW'(1);
            default: count_next = count_q;
        endcase
        af_next = (DEPTH_C - count_next) <= MARGIN_C;
    end

    // Storage array: written on push, never cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_tag, out_word};
        end
    end

    // Pointers, occupancy and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count_q     <= '0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count_q     <= count_next;
            almost_full <= af_next;
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Head entry is presented directly; it only moves on a pop.
    always_comb begin
        {out_tag, out_data} = mem[rd_ptr];
        out_valid           = (count_q != '0);
        count               = count_q;
    end

endmodule : des_out_stage

// File: tb/tb_des_out_stage.sv
// Directed bench for des_out_stage with immediate-assertion checks.
module tb_des_out_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_l16;
    logic [31:0] in_r16;
    logic [3:0]  in_tag;
    logic        almost_full;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [3:0]  out_tag;
    logic        overflow;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    des_out_stage #(.DEPTH(4), .TAG_W(4), .AF_MARGIN(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_l16      (in_l16),
        .in_r16      (in_r16),
        .in_tag      (in_tag),
        .almost_full (almost_full),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_tag     (out_tag),
        .overflow    (overflow),
        .count       (count)
    );

    always #5 clk = ~clk;

    // Standard DES FP table, 1-based, in DES notation.
    localparam int FP [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41, 9,  49, 17, 57, 25
    };

    function automatic logic [31:0] rev32(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = x[31-i];
        return r;
    endfunction

    function automatic logic [63:0] rev64(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[i] = x[63-i];
        return r;
    endfunction

    // x_des: DES bit k at position 64-k (MSB-first hex notation).
    function automatic logic [63:0] fp_des(input logic [63:0] x_des);
        logic [63:0] r;
        for (int k = 0; k < 64; k++) r[63-k] = x_des[64-FP[k]];
        return r;
    endfunction

    // Expected bus value from bus-ordered halves.
    function automatic logic [63:0] exp_bus(input logic [31:0] l_bus, input logic [31:0] r_bus);
        return rev64(fp_des({rev32(r_bus), rev32(l_bus)}));
    endfunction

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h required=%0h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] bl [5];
    logic [31:0] br [5];
    logic [3:0]  bt [5];
    logic [31:0] kv_l;
    logic [31:0] kv_r;
    logic [63:0] kv_ct;
    logic [67:0] sb [$];

    initial begin
        bl[0] = 32'h0123_4567; br[0] = 32'h89AB_CDEF; bt[0] = 4'h1;
        bl[1] = 32'hFFFF_0000; br[1] = 32'h0000_FFFF; bt[1] = 4'h2;
        bl[2] = 32'hDEAD_BEEF; br[2] = 32'hCAFE_F00D; bt[2] = 4'h3;
        bl[3] = 32'h8000_0001; br[3] = 32'h7FFF_FFFE; bt[3] = 4'h4;
        bl[4] = 32'h1357_9BDF; br[4] = 32'h2468_ACE0; bt[4] = 4'h5;

        rst_n = 1'b0; in_valid = 1'b0; in_l16 = '0; in_r16 = '0;
        in_tag = '0; out_ready = 1'b0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_af", almost_full, 0);
        chk("rst_ovf", overflow, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Known vector from the classic DES worked example.
        kv_l = 32'h4342_3234; kv_r = 32'h0A4C_D995; kv_ct = 64'h85E8_1354_0F0A_B405;
        in_l16 = rev32(kv_l); in_r16 = rev32(kv_r); in_tag = 4'hA;
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("kv_valid", out_valid, 1);
        chk("kv_data", out_data, rev64(kv_ct));
        chk("kv_tag", out_tag, 4'hA);
        tick();
        chk("kv_drained", count, 0);
        out_ready = 1'b0;

        // Fill without draining.
        for (int i = 0; i < 4; i++) begin
            in_l16 = bl[i]; in_r16 = br[i]; in_tag = bt[i]; in_valid = 1'b1;
            tick();
            chk("fill_count", count, i + 1);
            chk("fill_af", almost_full, (i + 1) >= 2);
            chk("fill_head", {out_tag, out_data}, {bt[0], exp_bus(bl[0], br[0])});
        end

        // Fifth block while full and not draining is dropped.
        in_l16 = bl[4]; in_r16 = br[4]; in_tag = bt[4];
        tick();
        in_valid = 1'b0;
        chk("ovf_flag", overflow, 1);
        chk("ovf_count", count, 4);
        tick();
        chk("ovf_sticky", overflow, 1);

        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", out_valid, 1);
            chk("drain_head", {out_tag, out_data}, {bt[i], exp_bus(bl[i], br[i])});
            tick();
        end
        chk("drain_empty", out_valid, 0);
        chk("drain_af", almost_full, 0);
        chk("drain_ovf", overflow, 1);
        out_ready = 1'b0;

        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        chk("ovf_cleared", overflow, 0);

        // Full FIFO with simultaneous push and pop.
        for (int i = 0; i < 4; i++) begin
            in_l16 = bl[i]; in_r16 = br[i]; in_tag = bt[i]; in_valid = 1'b1;
            tick();
        end
        chk("pp_full", count, 4);
        in_l16 = bl[4]; in_r16 = br[4]; in_tag = bt[4]; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("pp_count", count, 4);
        chk("pp_ovf", overflow, 0);
        for (int i = 1; i < 5; i++) begin
            chk("pp_order", {out_tag, out_data}, {bt[i], exp_bus(bl[i], br[i])});
            tick();
        end
        chk("pp_empty", count, 0);

        // Random stress against a scoreboard.
        begin
            int sent = 0;
            int cyc = 0;
            logic [31:0] rl, rr;
            logic [3:0] rt;
            logic do_pop, do_push;
            while ((sent < 1000 || sb.size() != 0) && cyc < 20000) begin
                chk("rs_count", count, sb.size());
                if (sb.size() != 0) chk("rs_head", {out_tag, out_data}, sb[0]);
                out_ready = 1'($urandom_range(0, 1));
                do_push = (sent < 1000) && !almost_full && ($urandom_range(0, 1) == 1);
                rl = $urandom; rr = $urandom; rt = 4'($urandom_range(0, 15));
                in_valid = do_push; in_l16 = rl; in_r16 = rr; in_tag = rt;
                do_pop = out_ready && (sb.size() != 0);
                tick();
                if (do_pop) void'(sb.pop_front());
                if (do_push) begin
                    sb.push_back({rt, exp_bus(rl, rr)});
                    sent++;
                end
                cyc++;
            end
            in_valid = 1'b0;
            chk("rs_done_in_time", cyc < 20000, 1);
            chk("rs_no_ovf", overflow, 0);
        end

        // Asynchronous reset with three entries buffered.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_l16 = bl[i]; in_r16 = br[i]; in_tag = bt[i]; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        chk("mr_count3", count, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_valid", out_valid, 0);
        chk("mr_count", count, 0);
        chk("mr_af", almost_full, 0);
        chk("mr_ovf", overflow, 0);
        #3;
        rst_n = 1'b1;
        tick();
        in_l16 = bl[3]; in_r16 = br[3]; in_tag = bt[3]; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("mr_after_valid", out_valid, 1);
        chk("mr_after_head", {out_tag, out_data}, {bt[3], exp_bus(bl[3], br[3])});
        chk("mr_after_count", count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_des_out_stage
